ysyx_22041207_if_id_queue: RTL and testbench
============================================

// Module: ysyx_22041207_if_id_queue
// PURPOSE
//  Fetch-to-decode boundary buffer: small FIFO between the IFU and the ID stage that feeds ID_EX.
//  - Decouples fetch from decode stalls and holds DEPTH fetched instructions.
//  - Discards wrong-path instructions after a redirect, using an epoch tag.
//  - The head entry drives the decoder directly.
// PARAMETERS
//  DEPTH    2   entries; power of two, 2..8
//  EPOCH_W  2   epoch tag width; wraps modulo 2^EPOCH_W
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   IFU presents a fetched instruction
//  in_ready   out  1   queue accepts this cycle (= !full)
//  in_pc      in   64  PC of fetched instruction
//  in_inst    in   32  instruction word
//  in_fault   in   1   instruction access fault on this fetch
//  in_epoch   in   EPOCH_W  epoch the IFU issued this fetch under
//  cur_epoch  out  EPOCH_W  current epoch, returned to IFU for tagging new fetches
//  flush      in   1   redirect (branch/jump/trap/mret): discard all contents
//  bubble     in   1   ID/ID_EX stalled: head must not be consumed
//  out_valid  out  1   head entry valid
//  out_pc     out  64  head PC
//  out_inst   out  32  head instruction
//  out_fault  out  1   head fault flag (decoder raises pc_panic)
//  occupancy  out  $clog2(DEPTH)+1  entry count, for debug/perf
// BEHAVIOUR
//  Reset (async):
//   - count=0, rd_ptr=wr_ptr=0, cur_epoch=0, storage cleared.
//   - Hence out_valid=0, in_ready=1, occupancy=0.
//  Empty outputs:
//   - out_valid=0, out_pc=0, out_inst=32'h00000013 (NOP), out_fault=0.
//  Non-empty outputs:
//   - out_* are the head entry read combinationally: zero-latency head, one-cycle push-to-visible.
//  Push (a flop, not combinational):
//   - push = in_valid & in_ready & (in_epoch==cur_epoch) & !flush.
//   - Stale-epoch pushes are accepted (in_ready handshake completes) but dropped silently.
//  Pop: pop = out_valid & !bubble & !flush.
//  Pointers: wrap modulo DEPTH.
//  Count update:
//   - count += push - pop.
//   - Simultaneous push+pop leaves count unchanged, including count==DEPTH-1.
//   - push cannot occur when full (in_ready=0), even if a pop happens the same cycle.
//  Flush:
//   - Next edge: count=0, rd_ptr=wr_ptr=0, cur_epoch=cur_epoch+1 (wraps 3->0 for EPOCH_W=2).
//   - A same-cycle push and pop are both ignored.
//   - out_valid is unaffected until the edge; ID_EX clears itself on flush.
//  Bubble: head held indefinitely; pushes continue until full.
//  Flush+bubble in the same cycle: flush wins.
//  Reset mid-operation: contents lost immediately; no partial state survives.
//  Occupancy always equals count; never exceeds DEPTH.
// TESTING
//  1. Reset, push pc=0x80000000 inst=0x00100093 epoch 0, bubble=0 -> out_valid next cycle with same pc/inst; popped the following edge; occupancy 1->0.
//  2. bubble=1, push 3 entries with DEPTH=2 -> in_ready=0 after 2; 3rd held by IFU; release bubble -> pops in order 0x80000000, 0x80000004, then 3rd accepted.
//  3. Full queue, flush=1 -> occupancy=0, cur_epoch=1, out_valid=0 next cycle; late push tagged epoch 0 accepted but never appears at out.
//  4. Flush four times from reset -> cur_epoch 1,2,3,0; push with in_epoch=0 after the 4th flush is stored.
//  5. count=1, push+pop same cycle -> occupancy stays 1; head advances to the newly pushed entry.
//  6. in_fault=1 push, then assert rst mid-stream -> out_fault=1 before reset; all outputs at reset values immediately on rst, before any clock edge.

Source files
------------

// File: rtl/ysyx_22041207_if_id_queue.sv
// IF->ID instruction queue: epoch-tagged FIFO whose head drives the decoder combinationally.
// Push visible one cycle later, head zero-latency; in_ready drops only when full, bubble holds the head.
module ysyx_22041207_if_id_queue #(
  parameter int DEPTH   = 2,
  parameter int EPOCH_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_fault,
  input  logic [EPOCH_W-1:0]       in_epoch,
  output logic [EPOCH_W-1:0]       cur_epoch,
  input  logic                     flush,
  input  logic                     bubble,
  output logic                     out_valid,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_fault,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [63:0]        pc_q    [DEPTH];
  logic [31:0]        inst_q  [DEPTH];
  logic               fault_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               full, push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count_q != '0);
  assign cur_epoch = epoch_q;
  assign occupancy = count_q;

  // Stale-epoch fetches still complete the handshake; they are simply not stored.
  assign push = in_valid & in_ready & (in_epoch == epoch_q) & !flush;
  assign pop  = out_valid & !bubble & !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    epoch_d  = epoch_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      epoch_d  = epoch_q + EPOCH_W'(1);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      epoch_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      epoch_q  <= epoch_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        inst_q[i]  <= '0;
        fault_q[i] <= 1'b0;
      end
    end else if (push) begin
      pc_q[wr_ptr_q]    <= in_pc;
      inst_q[wr_ptr_q]  <= in_inst;
      fault_q[wr_ptr_q] <= in_fault;
    end
  end

  always_comb begin
    out_pc    = '0;
    out_inst  = NOP;
    out_fault = 1'b0;
    if (out_valid) begin
      out_pc    = pc_q[rd_ptr_q];
      out_inst  = inst_q[rd_ptr_q];
      out_fault = fault_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_if_id_queue.sv
// Scoreboard bench for the IF->ID queue: driver queues expected heads, a negedge monitor checks each pop.
module tb_ysyx_22041207_if_id_queue;
  localparam int DEPTH   = 2;
  localparam int EPOCH_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_fault, flush, bubble;
  logic [63:0]        in_pc, out_pc;
  logic [31:0]        in_inst, out_inst;
  logic [EPOCH_W-1:0] in_epoch, cur_epoch;
  logic               out_valid, out_fault;
  logic [$clog2(DEPTH):0] occupancy;

  ysyx_22041207_if_id_queue #(.DEPTH(DEPTH), .EPOCH_W(EPOCH_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_fault(in_fault), .in_epoch(in_epoch), .cur_epoch(cur_epoch),
    .flush(flush), .bubble(bubble),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  ent_t               sb[$];
  int                 tests = 0;
  int                 fails = 0;
  logic [EPOCH_W-1:0] exp_epoch = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next edge whenever the head is valid and neither stalled nor flushed.
  always @(negedge clk) begin
    ent_t e;
    if (!rst && out_valid && !bubble && !flush) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got pc %0h, expected no entry", out_pc);
      end else begin
        e = sb.pop_front();
        check("pop_pc", out_pc, e.pc);
        check("pop_inst", {32'h0, out_inst}, {32'h0, e.inst});
        check("pop_fault", {63'h0, out_fault}, {63'h0, e.fault});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] inst, input logic f,
                      input logic [EPOCH_W-1:0] ep);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    in_fault = f;
    in_epoch = ep;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (ep == exp_epoch) sb.push_back('{pc, inst, f});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: pc %0h never accepted, expected handshake within 20 cycles", pc);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    sb.delete();
    exp_epoch = exp_epoch + EPOCH_W'(1);
    tick();
    flush = 1'b0;
  endtask

  initial begin
    logic [EPOCH_W-1:0] epoch_seq [3];
    epoch_seq = '{2'd2, 2'd3, 2'd0};

    rst = 1'b1; in_valid = 0; in_pc = '0; in_inst = '0; in_fault = 0;
    in_epoch = '0; flush = 0; bubble = 0;
    #2;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);
    check("rst_occupancy", 64'(occupancy), 64'h0);
    check("rst_out_inst", {32'h0, out_inst}, 64'h13);
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_cur_epoch", 64'(cur_epoch), 64'h0);
    tick(); tick();
    rst = 1'b0;

    // 1: single push, visible next cycle, popped the following edge
    push(64'h8000_0000, 32'h0010_0093, 1'b0, 2'd0);
    check("t1_occ_after_push", 64'(occupancy), 64'h1);
    check("t1_out_valid", {63'h0, out_valid}, 64'h1);
    check("t1_out_pc", out_pc, 64'h8000_0000);
    tick();
    check("t1_occ_after_pop", 64'(occupancy), 64'h0);
    check("t1_empty_inst", {32'h0, out_inst}, 64'h13);

    // 2 + 5: fill under bubble, third held, release; last step is push+pop at count 1
    bubble = 1'b1;
    push(64'h8000_0000, 32'h0000_0001, 1'b0, 2'd0);
    push(64'h8000_0004, 32'h0000_0002, 1'b0, 2'd0);
    check("t2_occ_full", 64'(occupancy), 64'h2);
    check("t2_in_ready_full", {63'h0, in_ready}, 64'h0);
    in_valid = 1'b1; in_pc = 64'h8000_0008; in_inst = 32'h0000_0003; in_epoch = 2'd0;
    tick();
    check("t2_occ_held", 64'(occupancy), 64'h2);
    check("t2_head_held", out_pc, 64'h8000_0000);
    bubble = 1'b0;
    push(64'h8000_0008, 32'h0000_0003, 1'b0, 2'd0);
    check("t5_occ_push_pop", 64'(occupancy), 64'h1);
    check("t5_head_new", out_pc, 64'h8000_0008);
    tick();
    check("t2_occ_drained", 64'(occupancy), 64'h0);

    // 3: flush a full queue under bubble, then a stale-epoch fetch is dropped
    bubble = 1'b1;
    push(64'h8000_0010, 32'h0000_0004, 1'b0, 2'd0);
    push(64'h8000_0014, 32'h0000_0005, 1'b0, 2'd0);
    check("t3_occ_full", 64'(occupancy), 64'h2);
    do_flush();
    check("t3_occ_flushed", 64'(occupancy), 64'h0);
    check("t3_epoch", 64'(cur_epoch), 64'h1);
    check("t3_out_valid", {63'h0, out_valid}, 64'h0);
    push(64'h9000_0000, 32'h0000_0006, 1'b0, 2'd0);
    check("t3_stale_occ", 64'(occupancy), 64'h0);
    check("t3_stale_valid", {63'h0, out_valid}, 64'h0);

    // 4: epoch wraps 3 -> 0, then epoch-0 fetch is stored again
    for (int k = 0; k < 3; k++) begin
      do_flush();
      check("t4_epoch", 64'(cur_epoch), 64'(epoch_seq[k]));
    end
    push(64'h8000_0100, 32'h0000_0007, 1'b0, 2'd0);
    check("t4_occ_stored", 64'(occupancy), 64'h1);
    check("t4_head_pc", out_pc, 64'h8000_0100);
    bubble = 1'b0;
    tick();
    check("t4_occ_drained", 64'(occupancy), 64'h0);

    // 6: faulting fetch, then asynchronous reset mid-cycle
    bubble = 1'b1;
    push(64'h8000_0200, 32'h0000_0008, 1'b1, 2'd0);
    check("t6_out_fault", {63'h0, out_fault}, 64'h1);
    #3;
    rst = 1'b1;
    sb.delete();
    exp_epoch = '0;
    #1;
    check("t6_rst_valid", {63'h0, out_valid}, 64'h0);
    check("t6_rst_fault", {63'h0, out_fault}, 64'h0);
    check("t6_rst_inst", {32'h0, out_inst}, 64'h13);
    check("t6_rst_occ", 64'(occupancy), 64'h0);
    check("t6_rst_ready", {63'h0, in_ready}, 64'h1);
    check("t6_rst_epoch", 64'(cur_epoch), 64'h0);
    tick();
    rst = 1'b0;
    bubble = 1'b0;
    tick();
    check("t6_post_rst_occ", 64'(occupancy), 64'h0);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries never popped, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
